// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and data
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_byte,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              stall_f,
    output logic              stall_d,
    output logic              err,
    output logic              m_req,
    output logic              m_we,
    output logic              m_byte,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack
);

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D, DONE} state_t;

    localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEADBEEF);
    localparam logic [7:0]        WDOG_LAST  = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;  // 1 = data was granted last
    logic [7:0] wdog;
    logic       grant_i;
    logic       grant_d;
    logic       timeout_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_i) begin
                    state_nxt = WAIT_I;
                end else if (grant_d) begin
                    state_nxt = WAIT_D;
                end
            end
            WAIT_I, WAIT_D: begin
                if (m_ack || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Under contention the port not granted last wins.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            if (if_req && d_req) begin
                grant_i = last_grant;
                grant_d = ~last_grant;
            end else begin
                grant_i = if_req;
                grant_d = d_req;
            end
        end
        timeout_hit = (wdog == WDOG_LAST);
        stall_f     = if_req & ~if_ready;
        stall_d     = d_req & ~d_ready;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_byte     <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
            err        <= 1'b0;
            last_grant <= 1'b0;
            wdog       <= '0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        m_req      <= 1'b1;
                        m_we       <= 1'b0;
                        m_byte     <= 1'b0;
                        m_addr     <= if_addr;
                        last_grant <= 1'b0;
                        wdog       <= '0;
                    end else if (grant_d) begin
                        m_req      <= 1'b1;
                        m_we       <= d_we;
                        m_byte     <= d_byte;
                        m_addr     <= d_addr;
                        m_wdata    <= d_wdata;
                        last_grant <= 1'b1;
                        wdog       <= '0;
                    end
                end
                WAIT_I: begin
                    if (m_ack) begin
                        m_req    <= 1'b0;
                        if_rdata <= m_rdata;
                        if_ready <= 1'b1;
                    end else if (timeout_hit) begin
                        m_req    <= 1'b0;
                        if_rdata <= ABORT_DATA;
                        if_ready <= 1'b1;
                        err      <= 1'b1;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end
                WAIT_D: begin
                    if (m_ack) begin
                        m_req   <= 1'b0;
                        d_ready <= 1'b1;
                        if (!m_we) begin
                            d_rdata <= m_rdata;
                        end
                    end else if (timeout_hit) begin
                        m_req   <= 1'b0;
                        d_ready <= 1'b1;
                        err     <= 1'b1;
                        if (!m_we) begin
                            d_rdata <= ABORT_DATA;
                        end
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic        d_byte;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        stall_f;
    logic        stall_d;
    logic        err;
    logic        m_req;
    logic        m_we;
    logic        m_byte;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;

    int tests;
    int failed;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .stall_f(stall_f), .stall_d(stall_d), .err(err),
        .m_req(m_req), .m_we(m_we), .m_byte(m_byte), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1);
    end

    task automatic test_reset();
        @(negedge clk);
        tests++; if (m_req !== 1'b0) begin failed++; $display("FAIL rst_m_req got=%b exp=0", m_req); end
        tests++; if (if_ready !== 1'b0 || d_ready !== 1'b0) begin failed++; $display("FAIL rst_ready got=%b%b exp=00", if_ready, d_ready); end
        tests++; if (err !== 1'b0) begin failed++; $display("FAIL rst_err got=%b exp=0", err); end
        tests++; if (m_addr !== 32'h0 || m_wdata !== 32'h0) begin failed++; $display("FAIL rst_m_addr_wdata got=%h/%h exp=0/0", m_addr, m_wdata); end
        tests++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin failed++; $display("FAIL rst_rdata got=%h/%h exp=0/0", if_rdata, d_rdata); end
        reset = 1'b1;
        @(negedge clk);
        tests++; if (m_req !== 1'b0) begin failed++; $display("FAIL rst_idle_m_req got=%b exp=0", m_req); end
    endtask

    task automatic test_single_fetch();
        if_req  = 1'b1;
        if_addr = 32'h0000_0008;
        @(negedge clk);
        tests++; if (m_req !== 1'b1) begin failed++; $display("FAIL sf_m_req got=%b exp=1", m_req); end
        tests++; if (m_addr !== 32'h8) begin failed++; $display("FAIL sf_m_addr got=%h exp=00000008", m_addr); end
        tests++; if (m_we !== 1'b0 || m_byte !== 1'b0) begin failed++; $display("FAIL sf_m_we_byte got=%b%b exp=00", m_we, m_byte); end
        tests++; if (stall_f !== 1'b1) begin failed++; $display("FAIL sf_stall_wait got=%b exp=1", stall_f); end
        m_ack   = 1'b1;
        m_rdata = 32'hE3A0_1005;
        @(negedge clk);
        m_ack = 1'b0;
        tests++; if (if_ready !== 1'b1) begin failed++; $display("FAIL sf_if_ready got=%b exp=1", if_ready); end
        tests++; if (if_rdata !== 32'hE3A0_1005) begin failed++; $display("FAIL sf_if_rdata got=%h exp=e3a01005", if_rdata); end
        tests++; if (m_req !== 1'b0) begin failed++; $display("FAIL sf_m_req_drop got=%b exp=0", m_req); end
        tests++; if (stall_f !== 1'b0) begin failed++; $display("FAIL sf_stall_ready got=%b exp=0", stall_f); end
        if_req = 1'b0;
        @(negedge clk);
        tests++; if (if_ready !== 1'b0) begin failed++; $display("FAIL sf_ready_one_cycle got=%b exp=0", if_ready); end
        tests++; if (m_req !== 1'b0) begin failed++; $display("FAIL sf_idle_m_req got=%b exp=0", m_req); end
    endtask

    task automatic test_contention();
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_byte  = 1'b0;
        d_addr  = 32'h0000_0040;
        @(negedge clk);
        tests++; if (m_addr !== 32'h40) begin failed++; $display("FAIL rr_first_data got=%h exp=00000040", m_addr); end
        tests++; if (stall_f !== 1'b1 || stall_d !== 1'b1) begin failed++; $display("FAIL rr_stalls_wait got=%b%b exp=11", stall_f, stall_d); end
        m_ack   = 1'b1;
        m_rdata = 32'h1111_2222;
        @(negedge clk);
        m_ack  = 1'b0;
        d_addr = 32'h0000_0044;
        tests++; if (d_ready !== 1'b1 || if_ready !== 1'b0) begin failed++; $display("FAIL rr_d_ready got=%b%b exp=10", d_ready, if_ready); end
        tests++; if (d_rdata !== 32'h1111_2222) begin failed++; $display("FAIL rr_d_rdata got=%h exp=11112222", d_rdata); end
        tests++; if (stall_f !== 1'b1 || stall_d !== 1'b0) begin failed++; $display("FAIL rr_stalls_done got=%b%b exp=10", stall_f, stall_d); end
        @(negedge clk);
        tests++; if (m_req !== 1'b0 || stall_f !== 1'b1) begin failed++; $display("FAIL rr_idle got=%b%b exp=01", m_req, stall_f); end
        @(negedge clk);
        tests++; if (m_req !== 1'b1 || m_addr !== 32'h100) begin failed++; $display("FAIL rr_second_fetch got=%b/%h exp=1/00000100", m_req, m_addr); end
        m_ack   = 1'b1;
        m_rdata = 32'hAAAA_5555;
        @(negedge clk);
        m_ack = 1'b0;
        tests++; if (if_ready !== 1'b1 || d_ready !== 1'b0) begin failed++; $display("FAIL rr_if_ready got=%b%b exp=10", if_ready, d_ready); end
        tests++; if (if_rdata !== 32'hAAAA_5555) begin failed++; $display("FAIL rr_if_rdata got=%h exp=aaaa5555", if_rdata); end
        if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++; if (m_req !== 1'b1 || m_addr !== 32'h44) begin failed++; $display("FAIL rr_third_data got=%b/%h exp=1/00000044", m_req, m_addr); end
        m_ack   = 1'b1;
        m_rdata = 32'h3333_4444;
        @(negedge clk);
        m_ack = 1'b0;
        tests++; if (d_ready !== 1'b1 || d_rdata !== 32'h3333_4444) begin failed++; $display("FAIL rr_third_ready got=%b/%h exp=1/33334444", d_ready, d_rdata); end
        d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_byte  = 1'b1;
        d_addr  = 32'h0000_0080;
        d_wdata = 32'h0000_00AB;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if (m_req !== 1'b1 || m_we !== 1'b1 || m_byte !== 1'b1) begin failed++; $display("FAIL st_ctrl_c%0d got=%b%b%b exp=111", i, m_req, m_we, m_byte); end
            tests++; if (m_wdata !== 32'hAB || m_addr !== 32'h80) begin failed++; $display("FAIL st_data_c%0d got=%h/%h exp=000000ab/00000080", i, m_wdata, m_addr); end
            d_wdata = 32'h0000_00FF;
            d_addr  = 32'h0000_0090;
        end
        m_ack   = 1'b1;
        m_rdata = 32'h9999_9999;
        @(negedge clk);
        m_ack = 1'b0;
        tests++; if (d_ready !== 1'b1 || err !== 1'b0) begin failed++; $display("FAIL st_ready got=%b%b exp=10", d_ready, err); end
        tests++; if (d_rdata !== 32'h3333_4444) begin failed++; $display("FAIL st_rdata_kept got=%h exp=33334444", d_rdata); end
        d_req  = 1'b0;
        d_we   = 1'b0;
        d_byte = 1'b0;
        @(negedge clk);
        tests++; if (d_ready !== 1'b0) begin failed++; $display("FAIL st_ready_one_cycle got=%b exp=0", d_ready); end
    endtask

    task automatic test_timeout();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_00C0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++; if (m_req !== 1'b1 || d_ready !== 1'b0) begin failed++; $display("FAIL to_wait_c%0d got=%b%b exp=10", i, m_req, d_ready); end
        end
        @(negedge clk);
        tests++; if (m_req !== 1'b0) begin failed++; $display("FAIL to_m_req_drop got=%b exp=0", m_req); end
        tests++; if (d_ready !== 1'b1 || err !== 1'b1) begin failed++; $display("FAIL to_ready_err got=%b%b exp=11", d_ready, err); end
        tests++; if (d_rdata !== 32'hDEAD_BEEF) begin failed++; $display("FAIL to_rdata got=%h exp=deadbeef", d_rdata); end
        d_req = 1'b0;
        @(negedge clk);
        tests++; if (err !== 1'b0 || d_ready !== 1'b0) begin failed++; $display("FAIL to_err_one_cycle got=%b%b exp=00", err, d_ready); end
    endtask

    task automatic test_reset_mid_wait();
        if_req  = 1'b1;
        if_addr = 32'h0000_0200;
        @(negedge clk);
        tests++; if (m_req !== 1'b1) begin failed++; $display("FAIL rw_granted got=%b exp=1", m_req); end
        #2 reset = 1'b0;
        #1;
        tests++; if (m_req !== 1'b0 || m_addr !== 32'h0) begin failed++; $display("FAIL rw_async got=%b/%h exp=0/00000000", m_req, m_addr); end
        tests++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin failed++; $display("FAIL rw_rdata_rst got=%h/%h exp=0/0", if_rdata, d_rdata); end
        if_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++; if (if_ready !== 1'b0) begin failed++; $display("FAIL rw_no_ready got=%b exp=0", if_ready); end
        m_ack   = 1'b1;
        m_rdata = 32'h5A5A_5A5A;
        @(negedge clk);
        m_ack = 1'b0;
        @(negedge clk);
        tests++; if (if_ready !== 1'b0 || d_ready !== 1'b0 || err !== 1'b0) begin failed++; $display("FAIL rw_stale_ack got=%b%b%b exp=000", if_ready, d_ready, err); end
        tests++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin failed++; $display("FAIL rw_stale_data got=%h/%h exp=0/0", if_rdata, d_rdata); end
        tests++; if (m_req !== 1'b0) begin failed++; $display("FAIL rw_stale_m_req got=%b exp=0", m_req); end
    endtask

    initial begin
        tests   = 0;
        failed  = 0;
        reset   = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_byte  = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        m_rdata = '0;
        m_ack   = 1'b0;
        test_reset();
        test_single_fetch();
        test_contention();
        test_store();
        test_timeout();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
